// File: rtl/div32_seq.sv
// div32_seq: iterative RV32M DIV/DIVU/REM/REMU sequencer.
// One XLEN+1-bit trial subtractor is reused over XLEN restoring-division steps,
// with sign handling around it and RISC-V divide-by-zero / overflow shortcuts.
// Optional macro DIV32_KILL_EN adds an i_kill input that aborts an operation.
module div32_seq #(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_start,
  input  logic [1:0]      i_op,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  output logic            o_busy,
  output logic            o_valid,
  input  logic            i_ready,
`ifdef DIV32_KILL_EN
  input  logic            i_kill,
`endif
  output logic [XLEN-1:0] o_result
);

  localparam int CNT_W = $clog2(XLEN);

  localparam logic [XLEN-1:0]  ZERO  = {XLEN{1'b0}};
  localparam logic [XLEN-1:0]  ONES  = {XLEN{1'b1}};
  localparam logic [XLEN-1:0]  MIN_S = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(XLEN - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_busy_nxt;
  logic             w_valid_nxt;

  logic             r_op_rem;   // 1: remainder requested, 0: quotient
  logic             r_sign_a;
  logic             r_sign_b;
  logic [XLEN-1:0]  r_rem;
  logic [XLEN-1:0]  r_quo;
  logic [XLEN-1:0]  r_div;
  logic [CNT_W-1:0] r_cnt;
  logic [XLEN-1:0]  r_result;
  logic             r_busy;
  logic             r_valid;

  logic             w_kill;
  logic             w_accept;
  logic             w_signed;
  logic             w_sa;
  logic             w_sb;
  logic [XLEN-1:0]  w_abs_a;
  logic [XLEN-1:0]  w_abs_b;
  logic             w_b_zero;
  logic             w_ovf;
  logic             w_special;
  logic [XLEN-1:0]  w_spec_res;
  logic [XLEN:0]    w_trial;
  logic [XLEN-1:0]  w_rem_sh;
  logic             w_ge;
  logic [XLEN-1:0]  w_q_fix;
  logic [XLEN-1:0]  w_r_fix;

`ifdef DIV32_KILL_EN
  assign w_kill = i_kill;
`else
  assign w_kill = 1'b0;
`endif

  // Accept decode: operand conditioning and special-case detection.
  assign w_accept   = (r_state == S_IDLE) & i_start & ~w_kill;
  assign w_signed   = ~i_op[0];
  assign w_sa       = w_signed & i_a[XLEN-1];
  assign w_sb       = w_signed & i_b[XLEN-1];
  assign w_abs_a    = w_sa ? (ZERO - i_a) : i_a;
  assign w_abs_b    = w_sb ? (ZERO - i_b) : i_b;
  assign w_b_zero   = (i_b == ZERO);
  assign w_ovf      = w_signed & (i_a == MIN_S) & (i_b == ONES);
  assign w_special  = w_b_zero | w_ovf;
  assign w_spec_res = w_b_zero ? (i_op[1] ? i_a  : ONES)
                               : (i_op[1] ? ZERO : MIN_S);

  // Shared trial subtractor: {rem, quo msb} - {0, divisor} as a + ~b + 1.
  assign w_trial  = {r_rem, r_quo[XLEN-1]} + {1'b1, ~r_div} + {{XLEN{1'b0}}, 1'b1};
  assign w_rem_sh = {r_rem[XLEN-2:0], r_quo[XLEN-1]};
  assign w_ge     = ~w_trial[XLEN];

  // Sign post-processing applied in FIX.
  assign w_q_fix = (r_sign_a ^ r_sign_b) ? (ZERO - r_quo) : r_quo;
  assign w_r_fix = r_sign_a ? (ZERO - r_rem) : r_rem;

  assign o_busy   = r_busy;
  assign o_valid  = r_valid;
  assign o_result = r_result;

  // State register plus registered busy/valid outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= w_busy_nxt;
      r_valid <= w_valid_nxt;
    end
  end

  // Next-state logic; kill overrides everything outside IDLE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = w_special ? S_DONE : S_CALC;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_CALC: begin
        if (w_kill) begin
          w_state_nxt = S_IDLE;
        end else if (r_cnt == CNT_ZERO) begin
          w_state_nxt = S_FIX;
        end else begin
          w_state_nxt = S_CALC;
        end
      end
      S_FIX: begin
        if (w_kill) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (w_kill || i_ready) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_DONE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output decode from the next state so busy/valid come straight from flops.
  always_comb begin
    w_busy_nxt  = 1'b0;
    w_valid_nxt = 1'b0;
    case (w_state_nxt)
      S_IDLE:  begin w_busy_nxt = 1'b0; w_valid_nxt = 1'b0; end
      S_CALC:  begin w_busy_nxt = 1'b1; w_valid_nxt = 1'b0; end
      S_FIX:   begin w_busy_nxt = 1'b1; w_valid_nxt = 1'b0; end
      S_DONE:  begin w_busy_nxt = 1'b1; w_valid_nxt = 1'b1; end
      default: begin w_busy_nxt = 1'b0; w_valid_nxt = 1'b0; end
    endcase
  end

  // Datapath: operand capture, one division step per CALC cycle, result load.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_op_rem <= 1'b0;
      r_sign_a <= 1'b0;
      r_sign_b <= 1'b0;
      r_rem    <= ZERO;
      r_quo    <= ZERO;
      r_div    <= ZERO;
      r_cnt    <= CNT_ZERO;
      r_result <= ZERO;
    end else if (w_accept) begin
      r_op_rem <= i_op[1];
      r_sign_a <= w_sa;
      r_sign_b <= w_sb;
      r_rem    <= ZERO;
      r_quo    <= w_abs_a;
      r_div    <= w_abs_b;
      r_cnt    <= CNT_LAST;
      if (w_special) begin
        r_result <= w_spec_res;
      end else begin
        r_result <= r_result;
      end
    end else if (r_state == S_CALC) begin
      r_rem <= w_ge ? w_trial[XLEN-1:0] : w_rem_sh;
      r_quo <= {r_quo[XLEN-2:0], w_ge};
      if (r_cnt != CNT_ZERO) begin
        r_cnt <= r_cnt - CNT_ONE;
      end else begin
        r_cnt <= r_cnt;
      end
    end else if ((r_state == S_FIX) && !w_kill) begin
      r_result <= r_op_rem ? w_r_fix : w_q_fix;
    end else begin
      r_result <= r_result;
    end
  end

endmodule

// File: tb/tb_div32_seq.sv
// Self-checking bench for div32_seq: directed vectors, expected results and
// latencies pushed to a queue at issue time, compared by a separate monitor
// when o_valid rises.
module tb_div32_seq;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        ready = 1'b1;
  logic        kill  = 1'b0;
  logic [1:0]  op    = 2'b00;
  logic [31:0] a     = 32'd0;
  logic [31:0] b     = 32'd0;
  logic        busy;
  logic        valid;
  logic [31:0] result;

  typedef struct {
    logic [31:0] res;
    int          acc;
    int          lat;
    string       name;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  localparam logic [1:0] DIV  = 2'b00;
  localparam logic [1:0] DIVU = 2'b01;
  localparam logic [1:0] REM  = 2'b10;
  localparam logic [1:0] REMU = 2'b11;

  div32_seq dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_start  (start),
    .i_op     (op),
    .i_a      (a),
    .i_b      (b),
    .o_busy   (busy),
    .o_valid  (valid),
    .i_ready  (ready),
`ifdef DIV32_KILL_EN
    .i_kill   (kill),
`endif
    .o_result (result)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  // Monitor: on each rising o_valid, pop the oldest expectation and compare.
  initial begin
    logic pv;
    exp_t e;
    pv = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (valid && !pv) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_valid: got result %h with nothing expected", result);
        end else begin
          e = q.pop_front();
          chk({e.name, "_res"}, result, e.res);
          chk({e.name, "_lat"}, 32'(cyc - e.acc + 1), 32'(e.lat));
        end
      end
      pv = valid;
    end
  end

  // Issue one operation; hold>0 keeps i_ready low that many DONE cycles.
  task automatic run(input string nm, input logic [1:0] o, input logic [31:0] x,
                     input logic [31:0] y, input logic [31:0] ex, input int lat,
                     input int hold);
    int n;
    logic [31:0] saved;
    @(negedge clk);
    ready = (hold == 0);
    op = o; a = x; b = y; start = 1'b1;
    q.push_back('{ex, cyc + 1, lat, nm});
    @(negedge clk);
    start = 1'b0;
    a = $urandom; b = $urandom;
    chk({nm, "_busy"}, 32'(busy), 32'd1);
    n = 0;
    while (!valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!valid) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got no o_valid expected o_valid within 100 cycles", nm);
    end
    if (hold > 0) begin
      saved = result;
      for (int i = 0; i < hold; i++) begin
        chk({nm, "_bp_valid"}, 32'(valid), 32'd1);
        chk({nm, "_bp_busy"}, 32'(busy), 32'd1);
        chk({nm, "_bp_result"}, result, saved);
        start = 1'b1;
        op = DIVU; a = 32'd50; b = 32'd5;
        @(negedge clk);
      end
      chk({nm, "_bp_final"}, result, saved);
      start = 1'b0;
      ready = 1'b1;
      @(negedge clk);
      chk({nm, "_hs_valid"}, 32'(valid), 32'd0);
      chk({nm, "_hs_busy"}, 32'(busy), 32'd0);
    end else begin
      n = 0;
      while (valid && n < 10) begin
        @(negedge clk);
        n++;
      end
      chk({nm, "_release"}, 32'(valid), 32'd0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no end expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Normal unsigned / signed divisions.
    run("divu_100_7",   DIVU, 32'd100,        32'd7,          32'd14,         34, 0);
    run("remu_100_7",   REMU, 32'd100,        32'd7,          32'd2,          34, 0);
    run("div_m7_2",     DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  34, 0);
    run("rem_m7_2",     REM,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  34, 0);
    run("div_7_m2",     DIV,  32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  34, 0);
    run("remu_big_16",  REMU, 32'hFFFF_FFFF,  32'h0000_0010,  32'h0000_000F,  34, 0);
    run("divu_min_m1",  DIVU, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          34, 0);

    // Special cases: one-cycle latency.
    run("div_5_0",      DIV,  32'd5,          32'd0,          32'hFFFF_FFFF,  1, 0);
    run("remu_5_0",     REMU, 32'd5,          32'd0,          32'd5,          1, 0);
    run("div_ovf",      DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1, 0);
    run("rem_ovf",      REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1, 0);

    // Backpressure, then a fresh request.
    run("divu_bp",      DIVU, 32'd1000,       32'd10,         32'd100,        34, 5);
    run("div_after_bp", DIV,  32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFF2,  34, 0);

    // Asynchronous reset in the middle of CALC.
    @(negedge clk);
    op = DIVU; a = 32'hFFFF_FFFF; b = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_valid", 32'(valid), 32'd0);
    chk("midrst_result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run("divu_max_1",   DIVU, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  34, 0);

`ifdef DIV32_KILL_EN
    // Kill during CALC: no result, back to IDLE next cycle.
    @(negedge clk);
    op = DIVU; a = 32'd1234; b = 32'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    chk("kill_busy", 32'(busy), 32'd0);
    chk("kill_valid", 32'(valid), 32'd0);
    run("divu_9_3",     DIVU, 32'd9,          32'd3,          32'd3,          34, 0);
`endif

    repeat (3) @(negedge clk);
    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
